// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: TX state
// encoding, register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] OFS_TXDATA = 32'd0;
  localparam logic [31:0] OFS_STATUS = 32'd4;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;

  // STATUS only has a nibble for the fill level, so larger counts pin at 15.
  function automatic logic [3:0] sat_count4(input logic [6:0] c);
    return (c > 7'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with a combinational head output, so the consumer
// can take the head in the same cycle it pops it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  // A push into a full FIFO is only legal when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes core stores into a TX FIFO,
// serialises queued bytes and exposes a combinational STATUS register.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t     state_reg;
  logic [15:0]   baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          overflow_reg;

  logic          hit_txdata;
  logic          hit_status;
  logic          push_req;
  logic          pop;
  logic          baud_done;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_wrdata;

  assign unused_wrdata = ^Mem_WrData[31:8];

  assign hit_txdata = (Mem_WrAddr == BASE_ADDR + OFS_TXDATA);
  assign hit_status = (Mem_WrAddr == BASE_ADDR + OFS_STATUS);
  assign push_req   = MemWrite && hit_txdata;
  assign pop        = (state_reg == IDLE) && !fifo_empty;
  assign baud_done  = (baud_reg == BAUD_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (Mem_WrData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rd_hit = hit_txdata || hit_status;

  always_comb begin
    rd_data = '0;
    if (hit_status) begin
      rd_data[ST_FULL]            = fifo_full;
      rd_data[ST_EMPTY]           = fifo_empty;
      rd_data[ST_BUSY]            = tx_busy;
      rd_data[ST_OVERFLOW]        = overflow_reg;
      rd_data[ST_COUNT_LSB +: 4]  = sat_count4(7'(fifo_count));
    end
  end

  // A dropped byte sets the flag even if a clear lands in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end else if (MemWrite && hit_status && Mem_WrData[ST_OVERFLOW]) begin
      overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_dout;
            baud_reg  <= '0;
            tx_reg    <= 1'b0;
            state_reg <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= shift_reg[0];
            state_reg   <= DATA;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              // Drive the next bit from the pre-shift value so tx stays registered.
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_reg  <= '0;
            state_reg <= IDLE;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: drives core stores, decodes the tx line into bytes
// and compares them against a queue of bytes expected to be transmitted.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int          C    = 4;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        tx;
  logic        tx_busy;

  int   err_cnt;
  int   chk_cnt;
  int   frames_seen;
  logic [7:0] sb_q[$];

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .rd_hit     (rd_hit),
    .rd_data    (rd_data),
    .tx         (tx),
    .tx_busy    (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Store held for one cycle; caller follows with another store or bus_idle.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWrite   = 1'b1;
    Mem_WrAddr = addr;
    Mem_WrData = data;
    @(negedge clk);
  endtask

  task automatic bus_idle();
    MemWrite   = 1'b0;
    Mem_WrData = 32'h0;
  endtask

  task automatic read_at(input logic [31:0] addr);
    MemWrite   = 1'b0;
    Mem_WrAddr = addr;
    #1;
  endtask

  // Line decoder: samples each bit mid-period, independent of DUT internals.
  initial begin : monitor
    bit         in_frame;
    int         t;
    logic [7:0] byte_rx;
    logic [7:0] exp_b;
    in_frame = 1'b0;
    t        = 0;
    byte_rx  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame) begin
          if (tx == 1'b0) begin
            in_frame = 1'b1;
            t        = 0;
          end
        end else begin
          t++;
        end
        if (in_frame && (t % C) == (C / 2)) begin
          if (t / C == 0) begin
            check_val("start_bit", {31'b0, tx}, 32'h0);
          end else if (t / C <= 8) begin
            byte_rx[t / C - 1] = tx;
          end else begin
            check_val("stop_bit", {31'b0, tx}, 32'h1);
            in_frame = 1'b0;
            frames_seen++;
            check_val("frame_expected", {31'b0, (sb_q.size() != 0)}, 32'h1);
            if (sb_q.size() != 0) begin
              exp_b = sb_q.pop_front();
              $display("frame %0d: rx 0x%02h exp 0x%02h", frames_seen, byte_rx, exp_b);
              check_val("frame_byte", {24'b0, byte_rx}, {24'b0, exp_b});
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int timeout;
    int low_cnt;
    err_cnt     = 0;
    chk_cnt     = 0;
    frames_seen = 0;
    reset       = 1'b1;
    MemWrite    = 1'b0;
    Mem_WrAddr  = 32'h0;
    Mem_WrData  = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset state
    read_at(BASE + 4);
    check_val("rst_rd_hit", {31'b0, rd_hit}, 32'h1);
    check_val("rst_status", rd_data, 32'h0000_0002);
    check_val("rst_tx", {31'b0, tx}, 32'h1);
    check_val("rst_busy", {31'b0, tx_busy}, 32'h0);
    @(negedge clk);

    // 2: single byte 0x55, latency and frame length
    store(BASE, 32'hFFFF_FF55);
    sb_q.push_back(8'h55);
    bus_idle();
    read_at(BASE + 4);
    check_val("lat_tx_high", {31'b0, tx}, 32'h1);
    check_val("lat_status_cnt1", rd_data, 32'h0000_0010);
    @(negedge clk);
    check_val("lat_tx_fall", {31'b0, tx}, 32'h0);
    check_val("lat_busy", {31'b0, tx_busy}, 32'h1);
    repeat (39) @(negedge clk);
    check_val("frame_busy_end", {31'b0, tx_busy}, 32'h1);
    @(negedge clk);
    check_val("frame_idle_after", {31'b0, tx_busy}, 32'h0);
    @(negedge clk);

    // 3: nine back-to-back stores fill the FIFO, tenth overflows
    for (int i = 1; i <= 9; i++) begin
      store(BASE, 32'(i));
      sb_q.push_back(8'(i));
    end
    bus_idle();
    read_at(BASE + 4);
    check_val("fill_status", rd_data, 32'h0000_0085);
    @(negedge clk);
    store(BASE, 32'h0000_000A);
    bus_idle();
    read_at(BASE + 4);
    check_val("ovf_status", rd_data, 32'h0000_008D);
    @(negedge clk);

    // 4: overflow clear needs bit3
    store(BASE + 4, 32'h0000_0000);
    bus_idle();
    read_at(BASE + 4);
    check_val("ovf_kept", {31'b0, rd_data[3]}, 32'h1);
    @(negedge clk);
    store(BASE + 4, 32'h0000_0008);
    bus_idle();
    read_at(BASE + 4);
    check_val("ovf_cleared", {31'b0, rd_data[3]}, 32'h0);

    // drain all queued frames
    timeout = 0;
    while (rd_data != 32'h0000_0002 && timeout < 600) begin
      @(negedge clk);
      read_at(BASE + 4);
      timeout++;
    end
    check_val("drain_status", rd_data, 32'h0000_0002);
    check_val("drain_sb_empty", 32'(sb_q.size()), 32'h0);
    @(negedge clk);

    // 5: reset mid-frame with bytes queued
    store(BASE, 32'h0000_00A5);
    sb_q.push_back(8'hA5);
    store(BASE, 32'h0000_003C);
    sb_q.push_back(8'h3C);
    store(BASE, 32'h0000_007E);
    sb_q.push_back(8'h7E);
    bus_idle();
    timeout = 0;
    while (tx !== 1'b0 && timeout < 20) begin
      @(negedge clk);
      timeout++;
    end
    check_val("rst_frame_started", {31'b0, tx}, 32'h0);
    repeat (14) @(negedge clk);
    #2;
    reset = 1'b1;
    sb_q.delete();
    read_at(BASE + 4);
    check_val("arst_tx", {31'b0, tx}, 32'h1);
    check_val("arst_busy", {31'b0, tx_busy}, 32'h0);
    check_val("arst_status", rd_data, 32'h0000_0002);
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    check_val("no_tx_after_rst", 32'(low_cnt), 32'h0);

    // 6: out-of-window access
    store(BASE + 8, 32'h0000_0077);
    bus_idle();
    read_at(BASE + 8);
    check_val("oow_rd_hit", {31'b0, rd_hit}, 32'h0);
    check_val("oow_rd_data", rd_data, 32'h0);
    read_at(BASE + 4);
    check_val("oow_status", rd_data, 32'h0000_0002);
    read_at(BASE);
    check_val("txdata_rd_hit", {31'b0, rd_hit}, 32'h1);
    check_val("txdata_rd_data", rd_data, 32'h0);
    repeat (5) @(negedge clk);
    check_val("oow_tx_idle", {31'b0, tx}, 32'h1);

    check_val("frames_total", 32'(frames_seen), 32'd10);
    check_val("sb_final_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
